// File: rtl/rs_latch_driver_if.sv
// Bundle of request, feedback and drive signals for rs_latch_driver.
// Handshake: a request is taken only on a rising clk edge where busy=0; requests while busy are dropped.
interface rs_latch_driver_if;
   logic       req_set;
   logic       req_reset;
   logic       q_fb;
   logic       set_o;
   logic       reset_o;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] state_dbg;

   modport master (
      output req_set,
      output req_reset,
      output q_fb,
      input  set_o,
      input  reset_o,
      input  busy,
      input  done,
      input  err,
      input  state_dbg
   );

   modport slave (
      input  req_set,
      input  req_reset,
      input  q_fb,
      output set_o,
      output reset_o,
      output busy,
      output done,
      output err,
      output state_dbg
   );
endinterface

// File: rtl/rs_latch_driver.sv
// Pulse controller for the set/reset inputs of an external NOR RS latch.
// Optional q feedback confirmation is enabled with the RS_FB_CHECK_EN macro.
module rs_latch_driver #(
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 2,
   parameter int TIMEOUT = 16
) (
   input logic clk,
   input logic reset,
   rs_latch_driver_if.slave bus
);

   localparam int MAX_PG  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int MAX_ALL = (MAX_PG > TIMEOUT) ? MAX_PG : TIMEOUT;
   localparam int CW      = $clog2(MAX_ALL + 1);

   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_W - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
`ifdef RS_FB_CHECK_EN
      , ST_WAIT_FB = 2'd3
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          target_q, target_d;
   logic          set_q, set_d;
   logic          rst_q, rst_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

`ifdef RS_FB_CHECK_EN
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   logic err_q, err_d;
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = bus.q_fb;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         err_q   <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   logic unused_q_fb;
   assign unused_q_fb = bus.q_fb;
   assign bus.err     = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      done_d   = 1'b0;
`ifdef RS_FB_CHECK_EN
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // reset request has priority when both arrive together
            if (bus.req_reset) begin
               state_d  = ST_PULSE;
               target_d = 1'b0;
               cnt_d    = '0;
            end else if (bus.req_set) begin
               state_d  = ST_PULSE;
               target_d = 1'b1;
               cnt_d    = '0;
            end
         end
         ST_PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
`ifdef RS_FB_CHECK_EN
               state_d = ST_WAIT_FB;
`else
               state_d = ST_IDLE;
               done_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
`ifdef RS_FB_CHECK_EN
         ST_WAIT_FB: begin
            if (sync2_q == target_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               // give up waiting; the timeout is remembered until reset
               state_d = ST_IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // drives derive from the single next state, so set and reset can never coincide
      set_d  = (state_d == ST_PULSE) &  target_d;
      rst_d  = (state_d == ST_PULSE) & ~target_d;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         target_q <= 1'b0;
         set_q    <= 1'b0;
         rst_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         set_q    <= set_d;
         rst_q    <= rst_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.set_o     = set_q;
   assign bus.reset_o   = rst_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.state_dbg = state_q;

endmodule
